// File: rtl/eje6_sweep_ctrl.sv
// Self-check sequencer for the eje6 logic block: steps {A,B,C,D} through 0..15,
// waits a settle interval per vector and compares the three realisations of f, g and h.
//
// state | meaning
// ------+---------------------------------------------------------
// IDLE  | waiting for start after reset; no results yet
// WAIT  | vector applied, settle counter running down
// CHECK | one-cycle compare of eje6 outputs, advance vector
// DONE  | sweep complete, results held until the next start
module eje6_sweep_ctrl #(
  parameter int unsigned SETTLE  = 1,
  parameter logic [2:0]  FUNC_EN = 3'b111
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  output logic       A,
  output logic       B,
  output logic       C,
  output logic       D,
  input  logic       f,
  input  logic       fPOS,
  input  logic       fSOP,
  input  logic       g,
  input  logic       gPOS,
  input  logic       gSOP,
  input  logic       h,
  input  logic       hPOS,
  input  logic       hSOP,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [4:0] err_count,
  output logic [3:0] first_err_vec,
  output logic [2:0] first_err_mask,
  output logic       err_valid
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WAIT  = 2'd1,
    S_CHECK = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam logic [3:0] CNT_LOAD = 4'(SETTLE - 1);

  state_t     state;
  state_t     state_nxt;
  logic [3:0] vec;
  logic [3:0] cnt;
  logic [2:0] mis;
  logic       launch;

  assign {A, B, C, D} = vec;

  assign launch = start && (state == S_IDLE || state == S_DONE);

  // A disabled function never flags, whatever eje6 drives on it.
  assign mis = FUNC_EN & {~(f == fPOS && f == fSOP),
                          ~(g == gPOS && g == gSOP),
                          ~(h == hPOS && h == hSOP)};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start) state_nxt = S_WAIT;
      S_WAIT:  if (cnt == 4'd0) state_nxt = S_CHECK;
      S_CHECK: state_nxt = (vec == 4'd15) ? S_DONE : S_WAIT;
      S_DONE:  if (start) state_nxt = S_WAIT;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    case (state)
      S_WAIT, S_CHECK: busy = 1'b1;
      S_DONE:          done = 1'b1;
      default:         ;
    endcase
  end

  assign pass = done && (err_count == 5'd0);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      vec            <= 4'd0;
      cnt            <= 4'd0;
      err_count      <= 5'd0;
      first_err_vec  <= 4'd0;
      first_err_mask <= 3'd0;
      err_valid      <= 1'b0;
    end else if (launch) begin
      vec            <= 4'd0;
      cnt            <= CNT_LOAD;
      err_count      <= 5'd0;
      first_err_vec  <= 4'd0;
      first_err_mask <= 3'd0;
      err_valid      <= 1'b0;
    end else if (state == S_WAIT) begin
      if (cnt != 4'd0) cnt <= cnt - 4'd1;
    end else if (state == S_CHECK) begin
      if (|mis) begin
        err_count <= err_count + 5'd1;
        if (!err_valid) begin
          first_err_vec  <= vec;
          first_err_mask <= mis;
          err_valid      <= 1'b1;
        end
      end
      if (vec != 4'd15) begin
        vec <= vec + 4'd1;
        cnt <= CNT_LOAD;
      end
    end
  end

endmodule
